// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: 16-bit frames of {cmd byte, data byte}.
// Reads capture the data-byte MISO samples into rsp_rdata.
module spi_reg_master #(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 3,
    parameter int REG_W   = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [REG_W-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [REG_W-1:0]  rsp_rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int FW = 8 + REG_W;
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'(FW - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t          r_state, w_state_n;
    logic [3:0]      r_div, w_div_n;
    logic [3:0]      r_bit, w_bit_n;
    logic            r_phase, w_phase_n;
    logic            r_write, w_write_n;
    logic [FW-1:0]   r_sh, w_sh_n;
    logic [REG_W-1:0] r_rx, w_rx_n;
    logic [REG_W-1:0] r_rdata, w_rdata_n;
    logic            w_div_last;
    logic            w_frame;
    logic [7:0]      w_cmd;

    assign w_div_last = (r_div == DIV_LAST);
    assign w_cmd      = {req_write, 7'(req_addr)};
    assign w_frame    = (r_state == SETUP) || (r_state == SHIFT) ||
                        (r_state == HOLD);

    always_comb begin
        w_state_n = r_state;
        w_div_n   = r_div;
        w_bit_n   = r_bit;
        w_phase_n = r_phase;
        w_write_n = r_write;
        w_sh_n    = r_sh;
        w_rx_n    = r_rx;
        w_rdata_n = r_rdata;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_n = SETUP;
                    w_div_n   = 4'd0;
                    w_write_n = req_write;
                    w_sh_n    = {w_cmd, req_write ? req_wdata : '0};
                end
            end
            SETUP: begin
                if (w_div_last) begin
                    w_state_n = SHIFT;
                    w_div_n   = 4'd0;
                    w_bit_n   = 4'd0;
                    w_phase_n = 1'b0;
                end else begin
                    w_div_n = r_div + 4'd1;
                end
            end
            SHIFT: begin
                if (!w_div_last) begin
                    w_div_n = r_div + 4'd1;
                end else begin
                    w_div_n = 4'd0;
                    if (!r_phase) begin
                        w_phase_n = 1'b1;
                    end else begin
                        // last cycle of the high phase: sample, then advance
                        w_phase_n = 1'b0;
                        w_rx_n    = {r_rx[REG_W-2:0], spi_miso};
                        if (r_bit == BIT_LAST) begin
                            w_state_n = HOLD;
                        end else begin
                            w_bit_n = r_bit + 4'd1;
                            w_sh_n  = {r_sh[FW-2:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                if (w_div_last) begin
                    w_state_n = GAP;
                    w_div_n   = 4'd0;
                    if (!r_write) w_rdata_n = r_rx;
                end else begin
                    w_div_n = r_div + 4'd1;
                end
            end
            GAP: begin
                if (w_div_last) begin
                    w_state_n = IDLE;
                    w_div_n   = 4'd0;
                end else begin
                    w_div_n = r_div + 4'd1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
            r_div   <= 4'd0;
            r_bit   <= 4'd0;
            r_phase <= 1'b0;
            r_write <= 1'b0;
            r_sh    <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
        end else if (ena) begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_bit   <= w_bit_n;
            r_phase <= w_phase_n;
            r_write <= w_write_n;
            r_sh    <= w_sh_n;
            r_rx    <= w_rx_n;
            r_rdata <= w_rdata_n;
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = (r_state == GAP) && (r_div == 4'd0);
    assign rsp_rdata = r_rdata;
    assign spi_cs_n  = ~w_frame;
    assign spi_clk   = (r_state == SHIFT) && r_phase;
    assign spi_mosi  = w_frame && r_sh[FW-1];

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: vector table of transactions plus
// back-to-back, mid-frame reset and enable-freeze sequences.
module tb_spi_reg_master;

    logic       clk = 1'b0;
    logic       rstb, ena, req_valid, req_ready, req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata, rsp_rdata;
    logic       rsp_valid, busy, spi_cs_n, spi_clk, spi_mosi;
    logic       miso = 1'b0;

    spi_reg_master dut (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .spi_cs_n  (spi_cs_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (miso)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // bus monitor and slave model, evaluated mid-cycle
    int          edges = 0, cs_low = 0, cs_high = 0, last_gap = 0;
    int          frames = 0, frame_rsp = 0, rsp_total = 0, sclk_bad = 0;
    logic [15:0] bits = '0;
    logic [15:0] slave_frame = '0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    int          acc_q[$];

    always @(negedge clk) begin
        if (prev_cs && !spi_cs_n) begin
            if (frames > 0) last_gap = cs_high;
            frames++;
            edges = 0; bits = '0; cs_low = 0; cs_high = 0; frame_rsp = 0;
            miso = slave_frame[15];
        end
        if (!spi_cs_n) cs_low++;
        else cs_high++;
        if (spi_clk && !prev_sclk) begin
            edges++;
            bits = {bits[14:0], spi_mosi};
        end
        if (!spi_clk && prev_sclk && edges < 16) miso = slave_frame[15-edges];
        if (spi_cs_n && spi_clk) sclk_bad++;
        if (rsp_valid) begin
            frame_rsp++;
            rsp_total++;
        end
        if (req_valid && req_ready && ena && rstb) acc_q.push_back(cyc + 1);
        prev_cs   = spi_cs_n;
        prev_sclk = spi_clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic txn(input string nm, input logic w, input logic [2:0] a,
                       input logic [7:0] d, input logic [7:0] sb,
                       input logic [7:0] ecmd, input logic [7:0] edata,
                       input logic [7:0] erd, input int fz);
        int acc, rc, t, extra, bad;
        logic [7:0] rd;
        logic [3:0] pins;
        bit got;
        extra = (fz >= 0) ? 10 : 0;
        acc = 0; rc = 0; rd = '0; got = 0;
        acc_q.delete();
        slave_frame = {8'h00, sb};
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
        chk({nm, "_accept"}, acc_q.size(), 1);
        if (acc_q.size() > 0) acc = acc_q[0];
        if (fz >= 0) begin
            t = 0;
            while (!(spi_cs_n == 1'b0 && edges >= fz) && t < 400) begin
                @(negedge clk); t++;
            end
            @(posedge clk); #1 ena = 1'b0;
            @(negedge clk);
            pins = {spi_cs_n, spi_clk, spi_mosi, busy};
            bad = 0;
            repeat (9) begin
                @(negedge clk);
                if ({spi_cs_n, spi_clk, spi_mosi, busy} !== pins) bad++;
            end
            @(posedge clk); #1 ena = 1'b1;
            chk({nm, "_frozen"}, bad, 0);
        end
        t = 0;
        while (!got && t < 600) begin
            @(negedge clk); t++;
            if (rsp_valid) begin
                got = 1; rc = cyc; rd = rsp_rdata;
            end
        end
        chk({nm, "_rsp_seen"}, got, 1);
        chk({nm, "_rsp_lat"}, rc - acc, 136 + extra);
        chk({nm, "_rdata"}, rd, erd);
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk); t++;
        end
        chk({nm, "_ready_lat"}, cyc + 1 - acc, 141 + extra);
        chk({nm, "_cmd"}, bits[15:8], ecmd);
        chk({nm, "_data"}, bits[7:0], edata);
        chk({nm, "_edges"}, edges, 16);
        chk({nm, "_cs_low"}, cs_low, 136 + extra);
        chk({nm, "_rsp_cnt"}, frame_rsp, 1);
    endtask

    typedef struct {
        logic       w;
        logic [2:0] a;
        logic [7:0] d, sb, ecmd, edata, erd;
        int         fz;
    } vec_t;

    vec_t vt[5];

    initial begin
        int t, r0;
        vt[0] = '{1'b1, 3'd2, 8'hA5, 8'h00, 8'h82, 8'hA5, 8'h00, -1};
        vt[1] = '{1'b0, 3'd6, 8'hFF, 8'h3C, 8'h06, 8'h00, 8'h3C, -1};
        vt[2] = '{1'b1, 3'd7, 8'h00, 8'hFF, 8'h87, 8'h00, 8'h3C, -1};
        vt[3] = '{1'b0, 3'd0, 8'h12, 8'hA5, 8'h00, 8'h00, 8'hA5, -1};
        vt[4] = '{1'b0, 3'd4, 8'h00, 8'hC3, 8'h04, 8'h00, 8'hC3, 5};

        rstb = 1'b0; ena = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        @(posedge clk); #1 rstb = 1'b1;
        @(negedge clk);
        chk("rel_ready", req_ready, 1);

        for (int i = 0; i < 5; i++)
            txn($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].d, vt[i].sb,
                vt[i].ecmd, vt[i].edata, vt[i].erd, vt[i].fz);

        // back-to-back with req_valid held, then a pulse while busy
        acc_q.delete();
        r0 = rsp_total;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd1; req_wdata = 8'h11;
        t = 0;
        while (acc_q.size() < 2 && t < 400) begin
            @(negedge clk); t++;
        end
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        t = 0;
        while (!req_ready && t < 300) begin
            @(negedge clk); t++;
        end
        repeat (3) @(negedge clk);
        chk("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() >= 2)
            chk("b2b_spacing", acc_q[1] - acc_q[0], 141);
        chk("b2b_gap_ge4", last_gap >= 4, 1);
        chk("b2b_rsp", rsp_total - r0, 2);
        chk("b2b_rdata", rsp_rdata, 8'hC3);

        // reset during the shift phase
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd5; req_wdata = 8'hF0;
        @(posedge clk); #1 req_valid = 1'b0;
        t = 0;
        while (!(spi_cs_n == 1'b0 && edges >= 8) && t < 400) begin
            @(negedge clk); t++;
        end
        #2 rstb = 1'b0;
        #1;
        chk("arst_cs_n", spi_cs_n, 1);
        chk("arst_sclk", spi_clk, 0);
        chk("arst_ready", req_ready, 1);
        chk("arst_rdata", rsp_rdata, 0);
        r0 = rsp_total;
        @(posedge clk); #1 rstb = 1'b1;
        repeat (150) @(negedge clk);
        chk("arst_no_rsp", rsp_total - r0, 0);
        txn("post_rst", 1'b1, 3'd3, 8'h5A, 8'h00, 8'h83, 8'h5A, 8'h00, -1);

        chk("sclk_idle_low", sclk_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
